mem_responder: RTL and testbench

- Unified instruction/data memory: the slave end of the multicycle CPU's memory interface.
- Serves the control unit's instruction fetches (i_or_d=0) and data loads/stores (i_or_d=1) through one request/ready handshake.
- Inserts a configurable number of wait states, so the CPU state machine is exercised with stalls rather than assuming single-cycle memory.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_array.sv | 26 ++
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'(WORD_BYTES - 1);

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |(addr_lsbs & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/ready handshake between the CPU control unit (master) and the memory (slave).
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              mem_ready;
    logic [DATA_W-1:0] read_data;
    logic              mem_err;

    modport master (
        output mem_req, mem_write, addr, write_data,
        input  mem_ready, read_data, mem_err
    );

    modport slave (
        input  mem_req, mem_write, addr, write_data,
        output mem_ready, read_data, mem_err
    );
endinterface

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write port, combinational read port.
module mem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_windex,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_rindex,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // NOTE: the array has no reset; contents survive reset and clearing it would turn it into flops.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_windex] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_rindex];

endmodule

// File: rtl/mem_responder.sv
// Memory slave with configurable wait states: IDLE accepts a request, WAIT stalls, RESP pulses ready.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_read_data;

    logic              w_resp;
    logic              w_misaligned;
    logic              w_we;
    logic [IDX_W-1:0]  w_index;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_unused;

    assign w_resp       = (r_state == S_RESP);
    assign w_misaligned = is_misaligned(r_addr[1:0]);
    assign w_index      = r_addr[2 +: IDX_W];
    assign w_unused     = ^r_addr[ADDR_W-1:IDX_W+2];

    // An aborting reset in RESP must also suppress the commit on that same edge.
    assign w_we = w_resp && r_write && !w_misaligned && !reset;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk      (clk),
        .i_we     (w_we),
        .i_windex (w_index),
        .i_wdata  (r_wdata),
        .i_rindex (w_index),
        .o_rdata  (w_rdata)
    );

    // NOTE: assign the default first so every path drives the result and no latch is inferred.
    always_comb begin
        w_resp_data = r_read_data;
        if (w_misaligned) begin
            w_resp_data = '0;
        end else if (!r_write) begin
            w_resp_data = w_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_req) begin
                        r_addr  <= bus.addr;
                        r_write <= bus.mem_write;
                        r_wdata <= bus.write_data;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(WAIT_LOAD);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_read_data <= w_resp_data;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Between responses the last result is held; mem_err only ever accompanies mem_ready.
    assign bus.mem_ready = w_resp;
    assign bus.read_data = w_resp ? w_resp_data : r_read_data;
    assign bus.mem_err   = w_resp && w_misaligned;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 responder driven by directed accesses.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset2;
    logic reset0;
    int   cyc;
    int   compared;
    int   mismatched;

    logic [31:0] last_rd [2];
    exp_t        q2 [$];
    exp_t        q0 [$];

    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) u_dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.slave)
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) u_dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            bus2.mem_req = req; bus2.mem_write = wr; bus2.addr = a; bus2.write_data = wd;
        end else begin
            bus0.mem_req = req; bus0.mem_write = wr; bus0.addr = a; bus0.write_data = wd;
        end
    endtask

    // Called and returns at a negedge. Inputs are scrambled right after acceptance to
    // prove the responder works from its latched copies.
    task automatic access(input bit sel, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] load_exp);
        exp_t e;
        bit   seen;
        int   w;
        w     = sel ? 2 : 0;
        e.err = (a[1:0] != 2'b00);
        e.cyc = cyc + w + 1;
        e.rd  = e.err ? 32'h0 : (wr ? last_rd[sel] : load_exp);
        last_rd[sel] = e.rd;
        if (sel) q2.push_back(e); else q0.push_back(e);
        drive(sel, 1'b1, wr, a, wd);
        @(posedge clk);
        #1 drive(sel, 1'b1, wr, a ^ 32'h4, ~wd);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = sel ? bus2.mem_ready : bus0.mem_ready;
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        check(sel ? "w2_ready_timeout" : "w0_ready_timeout", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon2
        exp_t e;
        if (bus2.mem_ready) begin
            if (q2.size() == 0) begin
                check("w2_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("w2_read_data", bus2.read_data, e.rd);
                check("w2_mem_err", 32'(bus2.mem_err), 32'(e.err));
                check("w2_ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.mem_ready) begin
            if (q0.size() == 0) begin
                check("w0_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("w0_read_data", bus0.read_data, e.rd);
                check("w0_mem_err", 32'(bus0.mem_err), 32'(e.err));
                check("w0_ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        reset2 = 1'b1;
        reset0 = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_w2_ready", 32'(bus2.mem_ready), 32'd0);
        check("rst_w2_err", 32'(bus2.mem_err), 32'd0);
        check("rst_w2_rdata", bus2.read_data, 32'h0);
        check("rst_w0_ready", 32'(bus0.mem_ready), 32'd0);
        check("rst_w0_err", 32'(bus0.mem_err), 32'd0);
        check("rst_w0_rdata", bus0.read_data, 32'h0);
        reset2 = 1'b0;
        reset0 = 1'b0;

        // Two wait states: store/load timing, wrap-around, latched inputs.
        access(1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0);
        access(1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF);
        access(1'b1, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0);
        access(1'b1, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5);
        access(1'b1, 1'b1, 32'h34,  32'h33333333, 32'h0);
        access(1'b1, 1'b1, 32'h30,  32'h11111111, 32'h0);
        access(1'b1, 1'b0, 32'h30,  32'h0,        32'h11111111);
        access(1'b1, 1'b0, 32'h34,  32'h0,        32'h33333333);

        // Reset in the middle of a store's wait states aborts it.
        access(1'b1, 1'b1, 32'h20, 32'h5555AAAA, 32'h0);
        access(1'b1, 1'b0, 32'h20, 32'h0,        32'h5555AAAA);
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'hFFFF0000);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b1, 32'h24, 32'h0000FFFF);
        @(negedge clk);
        reset2 = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("abort_ready", 32'(bus2.mem_ready), 32'd0);
        check("abort_err", 32'(bus2.mem_err), 32'd0);
        check("abort_rdata", bus2.read_data, 32'h0);
        reset2 = 1'b0;
        last_rd[1] = 32'h0;
        access(1'b1, 1'b0, 32'h20, 32'h0, 32'h5555AAAA);

        // Zero wait states: read-after-write, back-to-back, misalignment.
        access(1'b0, 1'b1, 32'h40,  32'hCAFEF00D, 32'h0);
        access(1'b0, 1'b0, 32'h40,  32'h0,        32'hCAFEF00D);
        access(1'b0, 1'b1, 32'h100, 32'h0BADF00D, 32'h0);
        access(1'b0, 1'b1, 32'h102, 32'h12345678, 32'h0);
        access(1'b0, 1'b0, 32'h100, 32'h0,        32'h0BADF00D);
        access(1'b0, 1'b0, 32'h101, 32'h0,        32'h0);
        access(1'b0, 1'b0, 32'h40,  32'h0,        32'hCAFEF00D);

        repeat (4) @(negedge clk);
        check("w2_queue_drained", 32'(q2.size()), 32'd0);
        check("w0_queue_drained", 32'(q0.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
